// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Holds the transmitter state encoding and the bit-time calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Clock cycles per serial bit (truncating division).
  function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: counts CLKS_PER_BIT cycles per bit and pulses bitDoneOut
// on the last cycle of each bit; restartIn holds the counter at zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clkIn,
  input  logic resetIn,
  input  logic restartIn,
  output logic bitDoneOut
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    bitDoneOut = !restartIn && (cnt_q == LAST_CNT);
    cnt_d      = cnt_q + CNT_W'(1);
    if (restartIn || bitDoneOut) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one word per frame and sends it LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit after the data.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic                  clkIn,
  input  logic                  resetIn,
  input  logic                  enableIn,
  input  logic [DATA_WIDTH-1:0] fifoDataIn,
  input  logic                  fifoEmptyIn,
  input  logic                  fifoReadReadyIn,
  output logic                  fifoReadEnableOut,
  output logic                  txOut,
  output logic                  busyOut,
  output logic [15:0]           wordsSentOut
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("fifo_uart_tx: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
  end

  uart_tx_state_t        state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [15:0]           words_q, words_d;
  logic                  restart;
  logic                  bit_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clkIn     (clkIn),
    .resetIn   (resetIn),
    .restartIn (restart),
    .bitDoneOut(bit_done)
  );

  always_comb begin
    state_d           = state_q;
    shift_d           = shift_q;
    idx_d             = idx_q;
    words_d           = words_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d          = parity_q;
`endif
    fifoReadEnableOut = 1'b0;
    txOut             = 1'b1;
    busyOut           = 1'b1;
    restart           = 1'b0;

    case (state_q)
      IDLE: begin
        busyOut = 1'b0;
        restart = 1'b1;
        if (enableIn && !fifoEmptyIn && fifoReadReadyIn) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        // Word is captured here so later FIFO head changes cannot disturb the frame.
        fifoReadEnableOut = 1'b1;
        restart           = 1'b1;
        shift_d           = fifoDataIn;
        idx_d             = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d          = ^fifoDataIn;
`endif
        state_d           = START;
      end
      START: begin
        txOut = 1'b0;
        if (bit_done) begin
          state_d = DATA;
        end
      end
      DATA: begin
        txOut = shift_q[0];
        if (bit_done) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef FIFO_UART_TX_PARITY_EN
        txOut = parity_q;
        if (bit_done) begin
          state_d = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (bit_done) begin
          words_d = words_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      words_q  <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      words_q  <= words_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign wordsSentOut = words_q;

endmodule
